keypad_operand_entry: RTL and testbench

- Parametrised successor of the two-operand keypad entry logic that feeds the Booth multiplier.
- Builds operands A and B from decimal keypad digits, with optional sign entry, saturation and an overflow flag.
- Presents the operand pair to the multiplier over a valid/ready handshake, then waits for the multiplier's done pulse before accepting new entry.
- Sits between the debounced keypad scanner and the Booth multiplier core.

---
 rtl/kpe_pkg.sv | 19 +
 rtl/decimal_accumulator.sv | 68 ++++++
 rtl/keypad_operand_entry.sv | 151 +++++++++++++++
 tb/tb_keypad_operand_entry.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/kpe_pkg.sv
// Shared key codes and controller state encoding for the keypad operand entry block.
package kpe_pkg;

   localparam logic [3:0] KEY_ENTER = 4'hA;
   localparam logic [3:0] KEY_SIGN  = 4'hB;
   localparam logic [3:0] KEY_CLEAR = 4'hC;

   typedef enum logic [1:0] {
      ENTRY_A   = 2'd0,
      ENTRY_B   = 2'd1,
      REQ       = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   function automatic logic is_digit(input logic [3:0] key);
      return key <= 4'd9;
   endfunction

endpackage

// File: rtl/decimal_accumulator.sv
// Decimal digit accumulator: magnitude, digit count, sign and sticky overflow
// for the operand currently being typed in.
module decimal_accumulator #(
   parameter int WIDTH      = 12,
   parameter int MAX_DIGITS = 4,
   parameter int SIGNED_EN  = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_digit_stb,
   input  logic [3:0]       i_digit,
   input  logic             i_sign_stb,
   input  logic             i_clear_stb,
   output logic [WIDTH-1:0] o_value,
   output logic             o_neg,
   output logic             o_ovf
);

   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);
   // Largest magnitude that still fits the operand, in the widened product width
   localparam logic [WIDTH+3:0] MAG_MAX = (SIGNED_EN != 0) ?
      {{5{1'b0}}, {(WIDTH-1){1'b1}}} : {{4{1'b0}}, {WIDTH{1'b1}}};

   logic [WIDTH-1:0] r_mag;
   logic [CW-1:0]    r_count;
   logic             r_neg;
   logic             r_ovf;
   logic [WIDTH+3:0] w_mag_ext;
   logic [WIDTH+3:0] w_next;

   assign w_mag_ext = {4'b0000, r_mag};
   assign w_next    = (w_mag_ext << 3) + (w_mag_ext << 1) + {{WIDTH{1'b0}}, i_digit};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mag   <= '0;
         r_count <= '0;
         r_neg   <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (i_clear_stb) begin
         r_mag   <= '0;
         r_count <= '0;
         r_neg   <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (i_sign_stb && (SIGNED_EN != 0))
            r_neg <= ~r_neg;
         if (i_digit_stb) begin
            if (r_count == CNT_MAX) begin
               r_ovf <= 1'b1;
            end else if (w_next > MAG_MAX) begin
               r_mag   <= MAG_MAX[WIDTH-1:0];
               r_ovf   <= 1'b1;
               r_count <= r_count + CW'(1);
            end else begin
               r_mag   <= w_next[WIDTH-1:0];
               r_count <= r_count + CW'(1);
            end
         end
      end
   end

   assign o_value = r_neg ? -r_mag : r_mag;
   assign o_neg   = r_neg;
   assign o_ovf   = r_ovf;

endmodule

// File: rtl/keypad_operand_entry.sv
// Two-operand keypad entry front end for the Booth multiplier: key edge detect,
// entry/handshake FSM and operand latches.
//
// state     | meaning
// ENTRY_A   | typing operand A
// ENTRY_B   | typing operand B
// REQ       | operand pair offered, waiting for op_ready
// WAIT_DONE | pair accepted, waiting for mult_done
module keypad_operand_entry
   import kpe_pkg::*;
#(
   parameter int WIDTH      = 12,
   parameter int MAX_DIGITS = 4,
   parameter int SIGNED_EN  = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [3:0]       i_key_value,
   input  logic             i_key_pressed,
   input  logic             i_op_ready,
   input  logic             i_mult_done,
   output logic [WIDTH-1:0] o_op_a,
   output logic [WIDTH-1:0] o_op_b,
   output logic             o_op_valid,
   output logic             o_entry_sel,
   output logic [WIDTH-1:0] o_display_value,
   output logic             o_neg_flag,
   output logic             o_ovf,
   output logic             o_busy
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_key_prev;
   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic             w_key_evt;
   logic             w_in_entry;
   logic             w_digit_stb;
   logic             w_sign_stb;
   logic             w_enter;
   logic             w_clear_all;
   logic             w_acc_clear;
   logic [WIDTH-1:0] w_value;

   // key_prev tracks the raw level in every state so a key held across the
   // return to ENTRY_A cannot fire a fresh event
   assign w_key_evt = i_key_pressed & ~r_key_prev;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ENTRY_A;
         r_key_prev <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_key_prev <= i_key_pressed;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ENTRY_A: begin
            if (w_key_evt && i_key_value == KEY_ENTER)
               w_state_nxt = ENTRY_B;
         end
         ENTRY_B: begin
            if (w_key_evt && i_key_value == KEY_ENTER)
               w_state_nxt = REQ;
            else if (w_key_evt && i_key_value == KEY_CLEAR)
               w_state_nxt = ENTRY_A;
         end
         REQ: begin
            if (i_op_ready)
               w_state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (i_mult_done)
               w_state_nxt = ENTRY_A;
         end
         default: w_state_nxt = ENTRY_A;
      endcase
   end

   always_comb begin
      w_in_entry  = 1'b0;
      o_op_valid  = 1'b0;
      o_busy      = 1'b0;
      o_entry_sel = 1'b0;
      w_acc_clear = 1'b0;
      case (r_state)
         ENTRY_A: w_in_entry = 1'b1;
         ENTRY_B: begin
            w_in_entry  = 1'b1;
            o_entry_sel = 1'b1;
         end
         REQ: begin
            o_op_valid  = 1'b1;
            o_busy      = 1'b1;
            o_entry_sel = 1'b1;
         end
         WAIT_DONE: begin
            o_busy      = 1'b1;
            o_entry_sel = 1'b1;
            w_acc_clear = i_mult_done;
         end
         default: ;
      endcase
      w_digit_stb = w_in_entry & w_key_evt & is_digit(i_key_value);
      w_sign_stb  = w_in_entry & w_key_evt & (i_key_value == KEY_SIGN);
      w_enter     = w_in_entry & w_key_evt & (i_key_value == KEY_ENTER);
      w_clear_all = w_in_entry & w_key_evt & (i_key_value == KEY_CLEAR);
      w_acc_clear = w_acc_clear | w_enter | w_clear_all;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_op_a <= '0;
         r_op_b <= '0;
      end else if (w_clear_all) begin
         r_op_a <= '0;
         r_op_b <= '0;
      end else if (w_enter) begin
         if (r_state == ENTRY_A)
            r_op_a <= w_value;
         else
            r_op_b <= w_value;
      end
   end

   decimal_accumulator #(
      .WIDTH      (WIDTH),
      .MAX_DIGITS (MAX_DIGITS),
      .SIGNED_EN  (SIGNED_EN)
   ) u_acc (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_digit_stb (w_digit_stb),
      .i_digit     (i_key_value),
      .i_sign_stb  (w_sign_stb),
      .i_clear_stb (w_acc_clear),
      .o_value     (w_value),
      .o_neg       (o_neg_flag),
      .o_ovf       (o_ovf)
   );

   assign o_op_a          = r_op_a;
   assign o_op_b          = r_op_b;
   assign o_display_value = w_value;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Bench for keypad_operand_entry: signed default build plus an unsigned build
// driven by the same keys; operand pairs are scoreboarded at each handshake.
module tb_keypad_operand_entry;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  key_value = 4'h0;
   logic        key_pressed = 1'b0;
   logic        op_ready = 1'b0;
   logic        mult_done = 1'b0;

   logic [11:0] op_a, op_b, disp;
   logic        op_valid, entry_sel, neg, ovf, busy;
   logic [11:0] u_op_a, u_op_b, u_disp;
   logic        u_op_valid, u_entry_sel, u_neg, u_ovf, u_busy;

   int          n_checks = 0;
   int          n_fail = 0;
   int          n_valid = 0;
   logic [23:0] sb_q[$];

   always #5 clk = ~clk;

   keypad_operand_entry #(.WIDTH(12), .MAX_DIGITS(4), .SIGNED_EN(1)) dut (
      .i_clk(clk), .i_rst(rst), .i_key_value(key_value), .i_key_pressed(key_pressed),
      .i_op_ready(op_ready), .i_mult_done(mult_done),
      .o_op_a(op_a), .o_op_b(op_b), .o_op_valid(op_valid), .o_entry_sel(entry_sel),
      .o_display_value(disp), .o_neg_flag(neg), .o_ovf(ovf), .o_busy(busy)
   );

   keypad_operand_entry #(.WIDTH(12), .MAX_DIGITS(4), .SIGNED_EN(0)) dut_u (
      .i_clk(clk), .i_rst(rst), .i_key_value(key_value), .i_key_pressed(key_pressed),
      .i_op_ready(op_ready), .i_mult_done(mult_done),
      .o_op_a(u_op_a), .o_op_b(u_op_b), .o_op_valid(u_op_valid), .o_entry_sel(u_entry_sel),
      .o_display_value(u_disp), .o_neg_flag(u_neg), .o_ovf(u_ovf), .o_busy(u_busy)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic press(input logic [3:0] k);
      key_value   = k;
      key_pressed = 1'b1;
      @(posedge clk); #1;
      key_pressed = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic pulse_done();
      mult_done = 1'b1;
      @(posedge clk); #1;
      mult_done = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard consumer: every accepted transfer must match the oldest expected pair
   always @(negedge clk) begin
      if (op_valid) n_valid++;
      if (!rst && op_valid && op_ready) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_xfer", 32'(sb_q.size()), 32'd1);
         end else begin
            logic [23:0] e;
            e = sb_q.pop_front();
            chk("sb_op_a", {20'd0, op_a}, {20'd0, e[23:12]});
            chk("sb_op_b", {20'd0, op_b}, {20'd0, e[11:0]});
         end
      end
   end

   initial begin
      int v0;
      #12 rst = 1'b0;
      @(posedge clk); #1;

      chk("rst_op_a", {20'd0, op_a}, 0);
      chk("rst_op_b", {20'd0, op_b}, 0);
      chk("rst_ctl", {27'd0, op_valid, entry_sel, neg, ovf, busy}, 0);
      chk("rst_disp", {20'd0, disp}, 0);

      // 1: 123 then 45, ready already high
      op_ready = 1'b1;
      press(4'h1); press(4'h2); press(4'h3);
      chk("t1_disp_123", {20'd0, disp}, 123);
      press(4'hA);
      chk("t1_sel_b", {31'd0, entry_sel}, 1);
      chk("t1_disp_clr", {20'd0, disp}, 0);
      press(4'h4); press(4'h5);
      v0 = n_valid;
      sb_q.push_back({12'd123, 12'd45});
      press(4'hA);
      cycles(3);
      chk("t1_valid_1cyc", 32'(n_valid - v0), 1);
      chk("t1_busy", {31'd0, busy}, 1);
      pulse_done();
      chk("t1_idle", {30'd0, busy, entry_sel}, 0);
      chk("t1_op_a_kept", {20'd0, op_a}, 123);

      // 2: negative operands
      press(4'h7); press(4'hB);
      chk("t2_neg_a", {31'd0, neg}, 1);
      chk("t2_disp_m7", {20'd0, disp}, 32'hFF9);
      press(4'hA);
      chk("t2_neg_cleared", {31'd0, neg}, 0);
      press(4'hB); press(4'h3);
      chk("t2_neg_b", {31'd0, neg}, 1);
      sb_q.push_back({12'hFF9, 12'hFFD});
      press(4'hA);
      pulse_done();

      // 3: saturation and digit limit
      press(4'h9); press(4'h9); press(4'h9); press(4'h9);
      chk("t3_sat", {20'd0, disp}, 2047);
      chk("t3_ovf", {31'd0, ovf}, 1);
      press(4'h5);
      chk("t3_5th_ignored", {20'd0, disp}, 2047);
      press(4'hA);
      chk("t3_op_a", {20'd0, op_a}, 2047);
      chk("t3_ovf_clr", {31'd0, ovf}, 0);

      // 4: stall in REQ, keys and early mult_done ignored
      op_ready = 1'b0;
      press(4'h1);
      sb_q.push_back({12'd2047, 12'd1});
      press(4'hA);
      press(4'h5); press(4'hC);
      pulse_done();
      cycles(1);
      chk("t4_valid_held", {31'd0, op_valid}, 1);
      chk("t4_op_a_held", {20'd0, op_a}, 2047);
      chk("t4_op_b_held", {20'd0, op_b}, 1);
      chk("t4_disp_ign", {20'd0, disp}, 0);
      key_value = 4'h8; key_pressed = 1'b1; op_ready = 1'b1;
      @(posedge clk); #1;
      key_pressed = 1'b0;
      cycles(1);
      chk("t4_wait_done", {30'd0, op_valid, busy}, 32'b01);
      key_value = 4'h7; key_pressed = 1'b1;
      pulse_done();
      cycles(3);
      key_pressed = 1'b0;
      cycles(1);
      chk("t4_back_a", {30'd0, busy, entry_sel}, 0);
      chk("t4_held_key_dropped", {20'd0, disp}, 0);

      // 5: long press is one digit; CLEAR wipes operands
      key_value = 4'h3; key_pressed = 1'b1;
      cycles(10);
      key_pressed = 1'b0;
      cycles(1);
      chk("t5_single_3", {20'd0, disp}, 3);
      press(4'h1); press(4'hA);
      chk("t5_op_a_31", {20'd0, op_a}, 31);
      press(4'h5); press(4'hC);
      chk("t5_clr_op_a", {20'd0, op_a}, 0);
      chk("t5_clr_op_b", {20'd0, op_b}, 0);
      chk("t5_clr_disp", {20'd0, disp}, 0);
      chk("t5_clr_sel", {31'd0, entry_sel}, 0);

      // 6: async reset mid-WAIT_DONE, then unsigned build reaches 4095
      op_ready = 1'b1;
      press(4'h2); press(4'hA); press(4'h3);
      sb_q.push_back({12'd2, 12'd3});
      press(4'hA);
      chk("t6_in_wait", {31'd0, busy}, 1);
      #3 rst = 1'b1;
      #1;
      chk("t6_rst_op_a", {20'd0, op_a}, 0);
      chk("t6_rst_ctl", {29'd0, busy, entry_sel, op_valid}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      press(4'hB); press(4'h4); press(4'h0); press(4'h9); press(4'h5);
      chk("t6_u_disp_4095", {20'd0, u_disp}, 32'hFFF);
      chk("t6_u_flags", {30'd0, u_neg, u_ovf}, 0);
      chk("t6_s_disp_m2047", {20'd0, disp}, 32'h801);
      chk("t6_s_flags", {30'd0, neg, ovf}, 32'b11);
      press(4'hA);
      chk("t6_u_op_a", {20'd0, u_op_a}, 32'hFFF);
      chk("t6_s_op_a", {20'd0, op_a}, 32'h801);
      press(4'hC);

      chk("sb_drained", 32'(sb_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
